// File: rtl/corr_pkg.sv
// Shared types and sizing helpers for the correlation peak finder and its index register.
package corr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Frame length in lags.
  function automatic int calc_n(input int samples, input int osf);
    return samples * osf;
  endfunction

  // Index width shared with the index register's load port.
  function automatic int calc_iw(input int samples, input int osf);
    return $clog2(samples * osf) + 1;
  endfunction

endpackage

// File: rtl/lag_counter.sv
// Lag counter for one correlation frame: clears, counts accepted samples and wraps after the last lag.
module lag_counter
  import corr_pkg::*;
#(
  parameter int N  = 1024,
  parameter int CW = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  localparam logic [CW-1:0] LAST_VAL = CW'(N - 1);

  assign last = (count == LAST_VAL);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/correlation_peak_finder.sv
// Scans one frame of correlation magnitudes, tracks the earliest maximum and writes its lag
// into the correlation index register via a one-cycle LD strobe.
module correlation_peak_finder
  import corr_pkg::*;
#(
  parameter int                SAMPLES   = 128,
  parameter int                OSF       = 8,
  parameter int                CORR_W    = 16,
  parameter logic [CORR_W-1:0] THRESHOLD = '0,
  localparam int               N         = calc_n(SAMPLES, OSF),
  localparam int               IW        = calc_iw(SAMPLES, OSF)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Valid,
  input  logic [CORR_W-1:0] Corr,
  output logic              LD,
  output logic [IW-1:0]     Index,
  output logic [CORR_W-1:0] PeakVal,
  output logic              NoPeak,
  output logic              Busy
);

  localparam int CW = IW - 1;

  state_t            state;
  state_t            state_next;
  logic              clear_cnt;
  logic              accept;
  logic              last;
  logic [CW-1:0]     count;
  logic              take;
  logic [CORR_W-1:0] peak_next;
  logic [CORR_W:0]   peak_inc;
  logic              above;

  lag_counter #(
    .N  (N),
    .CW (CW)
  ) u_lag_counter (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (clear_cnt),
    .inc   (accept),
    .count (count),
    .last  (last)
  );

  always_comb begin
    state_next = state;
    clear_cnt  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_next = SCAN;
          clear_cnt  = 1'b1;
        end
      end
      SCAN: begin
        if (Valid) begin
          accept = 1'b1;
          if (last) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Lag 0 always seeds the tracker; later lags must be strictly larger so ties keep the earliest lag.
  // The threshold test uses peak+1 > THRESHOLD, i.e. peak >= THRESHOLD, evaluated on the value
  // being written this cycle so the strobe lines up with the final Index/PeakVal.
  always_comb begin
    take      = accept && ((count == '0) || (Corr > PeakVal));
    peak_next = take ? Corr : PeakVal;
    peak_inc  = {1'b0, peak_next} + (CORR_W + 1)'(1);
    above     = peak_inc > {1'b0, THRESHOLD};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      Busy    <= 1'b0;
      LD      <= 1'b0;
      NoPeak  <= 1'b0;
      Index   <= '0;
      PeakVal <= '0;
    end else begin
      state  <= state_next;
      Busy   <= (state_next != IDLE);
      LD     <= accept && last && above;
      NoPeak <= accept && last && !above;
      if (take) begin
        PeakVal <= Corr;
        Index   <= {1'b0, count};
      end
    end
  end

endmodule

// File: doc/correlation_peak_finder.md
# correlation_peak_finder

Scans one frame of correlation magnitudes, one per lag over SAMPLES*OSF lags, and tracks the maximum and its lag index. At the end of the frame it emits a one-cycle load strobe with the winning index. The strobe and index drive the LD/Input load port of the correlation index register. This block is the writer for that register.

## Interface

Parameters:
- SAMPLES, 128: symbols per correlation window.
- OSF, 8: oversampling factor. Frame length N = SAMPLES*OSF lags.
- CORR_W, 16: width of the unsigned correlation magnitude.
- THRESHOLD, 0: minimum peak magnitude that yields a load. Width CORR_W.

Ports (IW = $clog2(SAMPLES*OSF)+1, matching the register's Input width):
- Clk, input, 1: single clock; all logic on rising edge.
- Reset, input, 1: asynchronous, active-low reset.
- Start, input, 1: begin a new frame scan. Honoured only in IDLE.
- Valid, input, 1: Corr carries the magnitude for the current lag.
- Corr, input, CORR_W: unsigned correlation magnitude.
- LD, output, 1: one-cycle load strobe to the index register.
- Index, output, IW: lag index of the peak (load data).
- PeakVal, output, CORR_W: magnitude at Index.
- NoPeak, output, 1: one-cycle strobe; the frame ended with the peak below THRESHOLD.
- Busy, output, 1: high in SCAN and DONE.

## Operation

- States are IDLE, SCAN and DONE. Reset enters IDLE.
- Reset values: LD=0, NoPeak=0, Busy=0, Index=0, PeakVal=0, lag counter=0.
- IDLE: Start=1 → SCAN. The lag counter clears to 0. Index and PeakVal keep their previous frame values until lag 0 is accepted.
- SCAN: each cycle with Valid=1 accepts Corr as lag = counter, then the counter increments.
  - Lag 0 loads PeakVal=Corr and Index=0 unconditionally.
  - Lag k>0 updates only if Corr > PeakVal (strict). Ties keep the earliest lag.
  - Valid=0 stalls. The counter and the tracked values hold.
- Acceptance of lag N-1 → DONE, and the counter wraps to 0.
  - DONE: if the final PeakVal >= THRESHOLD, assert LD; otherwise assert NoPeak. Exactly one of the two strobes fires for one cycle.
  - The next cycle returns to IDLE.
- Start in SCAN or DONE is ignored. Valid in IDLE or DONE is ignored; no counter or peak update.
- Index and PeakVal stay stable after DONE until lag 0 of the next frame.
- Reset asserted mid-scan: immediate return to all reset values. No LD or NoPeak is emitted for the aborted frame.
- Width rules: Index is zero-extended from the counter to IW bits. Max Index is N-1.

## Timing

- Start sampled high at edge t (IDLE) → Busy=1 from t+1. The first sample can be accepted at edge t+1.
- Last lag accepted at edge t → LD (or NoPeak) high during cycle t+1 with Index/PeakVal final. Busy=0 from t+2.
- Peak compare/update latency is 1 cycle from accepted sample to PeakVal/Index.
- Minimum frame time with Valid always high is N+2 cycles from Start to IDLE.
- Back-to-back: Start may be asserted in the first IDLE cycle after DONE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- Shared package corr_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - the functions/constants for N and IW derived from SAMPLES/OSF, shared with the index register.
- Sub-module lag_counter holds the count, clear, increment-on-Valid and terminal-count (last) logic for N lags. It is instantiated once.
- The top level holds the FSM, the compare/track registers and the strobe generation.

## Test plan

- Ramp: with SAMPLES=4 and OSF=2 (N=8), Corr = lag value 0..7 with Valid continuous → LD one cycle exactly 9 cycles after Start, Index=7, PeakVal=7.
- Tie: N=8, Corr = {5,9,3,9,1,0,0,0} → Index=1, PeakVal=9. The later equal value at lag 3 does not replace it.
- Threshold: THRESHOLD=10, all Corr=4 → NoPeak one cycle and LD stays 0. Repeat with one lag at 10 → LD=1 with that index.
- Stalls and ignores: random Valid gaps, plus Start pulses inside SCAN → same Index as the gap-free run, strobe delayed by the number of stall cycles, and no restart.
- Reset mid-scan: Reset low at lag 3 → all outputs 0 with no strobe. A new Start then completes normally with a correct Index.
- Defaults: SAMPLES=128, OSF=8, peak 0xFFFF at lag 1023 → Index=1023 (IW=11), LD one cycle, Busy low 2 cycles after the last sample.
